// File: rtl/axi_dma_writer_pkg.sv
// Shared definitions for the AXI4 burst write master.
// Holds AXI field encodings, the 4 KB page size, the FSM state type and the
// burst-length helper used by axi_dma_writer.
package axi_dma_writer_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [3:0] AXI_CACHE_BUF  = 4'b0011;
    localparam int unsigned AXI_4K_BYTES  = 4096;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StResp,
        StFin
    } state_e;

    // Beats for the next burst: limited by the words left, the burst cap and the
    // words remaining before the next 4 KB page. addr_lo is word aligned, so the
    // shift is exact and the result is never 0 while remaining != 0.
    function automatic logic [8:0] calc_blen(input logic [31:0]  remaining,
                                             input logic [11:0]  addr_lo,
                                             input int unsigned  burst_max);
        logic [31:0] to_4k_words;
        logic [31:0] len;
        to_4k_words = (32'(AXI_4K_BYTES) - {20'd0, addr_lo}) >> 2;
        len = burst_max;
        if (remaining < len) len = remaining;
        if (to_4k_words < len) len = to_4k_words;
        return 9'(len);
    endfunction

endpackage

// File: rtl/axi_dma_writer_sync_fifo.sv
// Synchronous FIFO with the head word read straight from the storage flops.
// Ports: clk/rstn (async active-low), push_i/wdata_i write side, pop_i/head_o
// read side, full_o/empty_o/count_o occupancy. Pushes while full and pops
// while empty are dropped. DEPTH must be a power of 2.
module axi_dma_writer_sync_fifo #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push_i,
    input  logic [DW-1:0]            wdata_i,
    input  logic                     pop_i,
    output logic [DW-1:0]            head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
            else if (pop_ok && !push_ok) count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/axi_dma_writer.sv
// AXI4 burst write master: drains a 32-bit word stream into memory starting at
// base_addr, in INCR bursts that never cross a 4 KB page, then pulses done.
// Ports: clk/rstn (async active-low); start/base_addr/num_words request;
// busy/done/err status; s_valid/s_ready/s_data input stream (buffered in a
// FIFO that accepts data in every state); M_AW*/M_W*/M_B* AXI write channels.
// Optional: define AXI_WR_PERF_CNT_EN to add perf_cycles (busy cycles) and
// perf_wstall (W beats stalled by M_WREADY), both saturating, cleared on start.
module axi_dma_writer
    import axi_dma_writer_pkg::*;
#(
    parameter int unsigned AXI_WIDTH_AD = 32,
    parameter int unsigned AXI_WIDTH_ID = 4,
    parameter int unsigned AXI_WIDTH_DA = 32,
    parameter int unsigned AXI_WIDTH_DS = 4,
    parameter int unsigned BURST_MAX    = 16,
    parameter int unsigned FIFO_DEPTH   = 32,
    parameter int unsigned CNT_W        = 20
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [AXI_WIDTH_AD-1:0] base_addr,
    input  logic [CNT_W-1:0]        num_words,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
`ifdef AXI_WR_PERF_CNT_EN
    output logic [31:0]             perf_cycles,
    output logic [31:0]             perf_wstall,
`endif
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [AXI_WIDTH_DA-1:0] s_data,
    output logic                    M_AWVALID,
    input  logic                    M_AWREADY,
    output logic [AXI_WIDTH_AD-1:0] M_AWADDR,
    output logic [AXI_WIDTH_ID-1:0] M_AWID,
    output logic [7:0]              M_AWLEN,
    output logic [2:0]              M_AWSIZE,
    output logic [1:0]              M_AWBURST,
    output logic [1:0]              M_AWLOCK,
    output logic [3:0]              M_AWCACHE,
    output logic [2:0]              M_AWPROT,
    output logic                    M_WVALID,
    input  logic                    M_WREADY,
    output logic [AXI_WIDTH_DA-1:0] M_WDATA,
    output logic [AXI_WIDTH_DS-1:0] M_WSTRB,
    output logic                    M_WLAST,
    output logic [AXI_WIDTH_ID-1:0] M_WID,
    input  logic                    M_BVALID,
    output logic                    M_BREADY,
    input  logic [1:0]              M_BRESP,
    input  logic [AXI_WIDTH_ID-1:0] M_BID
);

    state_e                    state_q, state_d;
    logic [AXI_WIDTH_AD-1:0]   cur_addr_q, cur_addr_d;
    logic [CNT_W-1:0]          remaining_q, remaining_d;
    logic [8:0]                blen_q, blen_d;
    logic [8:0]                beat_q, beat_d;
    logic                      awvalid_q, awvalid_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      rdy_en_q;

    logic                      fifo_full, fifo_empty;
    logic [AXI_WIDTH_DA-1:0]   fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                      w_valid, w_fire, w_last;
    logic                      unused_sig;

    assign unused_sig = ^{base_addr[1:0], M_BID, fifo_count};

    axi_dma_writer_sync_fifo #(
        .DW    (AXI_WIDTH_DA),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (s_valid && s_ready),
        .wdata_i (s_data),
        .pop_i   (w_fire),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            blen_q      <= '0;
            beat_q      <= '0;
            awvalid_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            blen_q      <= blen_d;
            beat_q      <= beat_d;
            awvalid_q   <= awvalid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            // Holds s_ready low while in reset, where the FIFO reads as empty.
            rdy_en_q    <= 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = (num_words == '0) ? StFin : StAddr;
            StAddr: if (awvalid_q && M_AWREADY) state_d = StData;
            StData: if (w_fire && w_last) state_d = StResp;
            StResp: if (M_BVALID) state_d = (remaining_q == CNT_W'(blen_q)) ? StFin : StAddr;
            StFin:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values. The first ADDR cycle computes the burst length; the
    // address phase is presented from the second cycle onward.
    always_comb begin
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        blen_d      = blen_q;
        beat_d      = beat_q;
        awvalid_d   = awvalid_q;
        busy_d      = busy_q;
        err_d       = err_q;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cur_addr_d  = {base_addr[AXI_WIDTH_AD-1:2], 2'b00};
                    remaining_d = num_words;
                    err_d       = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            StAddr: begin
                if (!awvalid_q) begin
                    blen_d    = calc_blen(32'(remaining_q), cur_addr_q[11:0], BURST_MAX);
                    beat_d    = '0;
                    awvalid_d = 1'b1;
                end else if (M_AWREADY) begin
                    awvalid_d = 1'b0;
                end
            end
            StData: begin
                if (w_fire) beat_d = beat_q + 9'd1;
            end
            StResp: begin
                if (M_BVALID) begin
                    if (M_BRESP != AXI_RESP_OKAY) err_d = 1'b1;
                    cur_addr_d  = cur_addr_q + AXI_WIDTH_AD'({blen_q, 2'b00});
                    remaining_d = remaining_q - CNT_W'(blen_q);
                end
            end
            StFin: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Outputs.
    always_comb begin
        w_valid   = (state_q == StData) && !fifo_empty;
        w_fire    = w_valid && M_WREADY;
        w_last    = (beat_q == blen_q - 9'd1);
        busy      = busy_q;
        done      = done_q;
        err       = err_q;
        s_ready   = rdy_en_q && !fifo_full;
        M_AWVALID = awvalid_q;
        M_AWADDR  = awvalid_q ? cur_addr_q : '0;
        M_AWLEN   = awvalid_q ? 8'(blen_q - 9'd1) : '0;
        M_AWID    = '0;
        M_AWSIZE  = AXI_SIZE_4B;
        M_AWBURST = AXI_BURST_INCR;
        M_AWLOCK  = '0;
        M_AWCACHE = AXI_CACHE_BUF;
        M_AWPROT  = '0;
        M_WVALID  = w_valid;
        M_WDATA   = w_valid ? fifo_head : '0;
        M_WSTRB   = '1;
        M_WLAST   = w_valid && w_last;
        M_WID     = '0;
        M_BREADY  = (state_q == StResp);
    end

`ifdef AXI_WR_PERF_CNT_EN
    logic [31:0] perf_cycles_q, perf_wstall_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_cycles_q <= '0;
            perf_wstall_q <= '0;
        end else if (start && (state_q == StIdle)) begin
            perf_cycles_q <= '0;
            perf_wstall_q <= '0;
        end else begin
            if (busy_q && (perf_cycles_q != '1)) perf_cycles_q <= perf_cycles_q + 32'd1;
            if (w_valid && !M_WREADY && (perf_wstall_q != '1)) begin
                perf_wstall_q <= perf_wstall_q + 32'd1;
            end
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_wstall = perf_wstall_q;
`endif

endmodule

// File: doc/axi_dma_writer.md
Name: axi_dma_writer

Overview:
- AXI4 burst write master. Drains the postprocessor's 32-bit output-word stream into DRAM (the write side of yolo_engine's M_AW*/M_W*/M_B* channels).
- It is the initiator paired with the axi_sram_if responder used in simulation.
- Software-visible behaviour: on start, writes num_words consecutive words from base_addr, splitting the transfer into INCR bursts that never cross a 4 KB boundary, then pulses done.

Parameters:
- AXI_WIDTH_AD, 32, address width
- AXI_WIDTH_ID, 4, ID width; AWID/WID are constant 0
- AXI_WIDTH_DA, 32, data width; only 32 is supported
- AXI_WIDTH_DS, 4, strobe width (DA/8)
- BURST_MAX, 16, maximum beats per burst (1..256)
- FIFO_DEPTH, 32, input FIFO depth; power of 2, at least BURST_MAX
- CNT_W, 20, width of num_words and the internal beat counters

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle transfer request
- base_addr  in  AXI_WIDTH_AD  byte address; bits [1:0] ignored (forced 0)
- num_words  in  CNT_W  transfer length in words
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky: a BRESP != OKAY was seen in the current or last transfer
- s_valid  in  1  input word valid
- s_ready  out  1  = FIFO not full
- s_data  in  AXI_WIDTH_DA  input word
- M_AWVALID out 1; M_AWREADY in 1; M_AWADDR out AD; M_AWID out ID; M_AWLEN out 8; M_AWSIZE out 3 (=3'b010); M_AWBURST out 2 (=INCR); M_AWLOCK out 2 (=0); M_AWCACHE out 4 (=4'b0011); M_AWPROT out 3 (=0)
- M_WVALID out 1; M_WREADY in 1; M_WDATA out DA; M_WSTRB out DS (all ones); M_WLAST out 1; M_WID out ID
- M_BVALID in 1; M_BREADY out 1; M_BRESP in 2; M_BID in ID

Behaviour:
- Reset values: all outputs 0, except the constant AXI fields, which are always driven. The FIFO is emptied and the FSM returns to IDLE.
- States: IDLE, ADDR, DATA, RESP, FIN.
- IDLE:
  - start latches base_addr (with [1:0]=0) into cur_addr and num_words into remaining, clears err, sets busy.
  - If num_words=0 the FSM goes to FIN; otherwise to ADDR.
  - start while busy is ignored.
- ADDR:
  - On entry, compute blen = min(remaining, BURST_MAX, (4096 - cur_addr[11:0])>>2). The result is always at least 1.
  - Drive M_AWADDR=cur_addr and M_AWLEN=blen-1, and hold them stable with M_AWVALID until M_AWREADY.
  - On the handshake, go to DATA.
- DATA:
  - M_WVALID = FIFO not empty; M_WDATA = FIFO head.
  - The FIFO pops on M_WVALID & M_WREADY.
  - M_WLAST is high on beat blen-1.
  - Once M_WVALID is asserted it must not drop until that beat's handshake (the head is registered; an empty FIFO simply delays assertion).
  - After the last-beat handshake, go to RESP.
- RESP:
  - M_BREADY=1.
  - On M_BVALID: if M_BRESP != 0, set err; cur_addr += blen*4; remaining -= blen.
  - Go to ADDR if remaining != 0, else FIN.
- FIN: done=1 for one cycle, busy=0, go to IDLE.
- Only one burst is outstanding; AW always precedes W.
- The FIFO accepts input in every state, including IDLE: the producer may run ahead of start.
- Simultaneous FIFO push and pop when full is allowed: s_ready reflects full before the pop.
- Minimum latency from start to the first M_AWVALID is 2 cycles.
- Address arithmetic is modulo 2^AXI_WIDTH_AD.
- An error response does not abort the transfer; remaining bursts are still issued.

Optional Feature:
- AXI_WR_PERF_CNT_EN defined: adds outputs perf_cycles[31:0] and perf_wstall[31:0].
  - perf_cycles counts cycles with busy=1.
  - perf_wstall counts DATA cycles with M_WVALID & !M_WREADY.
  - Both clear on an accepted start and saturate at all-ones.
- Not defined: neither the ports nor the counter logic exist.

Decomposition:
- Shared package/header axi_defs.vh holds AXI_BURST_INCR, AXI_RESP_OKAY, AXI_SIZE_4B, AXI_4K_BYTES and the FSM state encodings.
- One sub-module, sync_fifo (params DW, DEPTH): push/pop/full/empty/count, registered head output.

Test Plan:
- Setup: every scenario runs against axi_sram_if + sram, with zero-wait AW/W ready unless noted.
- base=0x0000_0800, num_words=40, BURST_MAX=16, words 0..39 pre-pushed -> bursts of AWLEN 15,15,7 at 0x800, 0x840, 0x880; SRAM holds 0..39; one done pulse; err=0.
- base=0x0000_0FF0, num_words=10 -> AWLEN=3 at 0xFF0, then AWLEN=5 at 0x1000; no burst crosses 4 KB.
- num_words=0 -> no AXI activity; done two cycles after start.
- Producer pushes one word every 5 cycles and M_WREADY toggles randomly -> M_WVALID never falls without a handshake; M_WLAST only on beat blen-1; data order preserved.
- Responder returns BRESP=2'b10 on burst 2 of 3 -> err=1 at done; all 3 bursts issued; a following start clears err.
- rstn asserted mid-DATA -> all outputs 0 immediately; after release, a fresh 8-word transfer completes correctly.
